// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the instruction queue between IF and ID.
// master = fetch/decode side, slave = the queue itself.
interface if_id_queue_if #(
    parameter int unsigned DEPTH = 2
);
    logic                         in_valid;
    logic [31:0]                  in_instn;
    logic [31:0]                  in_pc;
    logic                         in_ready;
    logic                         stall_flag;
    logic                         flush;
    logic                         out_valid;
    logic [31:0]                  out_instn;
    logic [31:0]                  out_pc;
    logic [31:0]                  out_pc_plus4;
    logic                         jump_detect;
    logic [25:0]                  jump_address;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_instn, in_pc, stall_flag, flush,
        input  in_ready, out_valid, out_instn, out_pc, out_pc_plus4,
               jump_detect, jump_address, count
    );

    modport slave (
        input  in_valid, in_instn, in_pc, stall_flag, flush,
        output in_ready, out_valid, out_instn, out_pc, out_pc_plus4,
               jump_detect, jump_address, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {instn, pc} with flush on redirect
// and J/JAL predecode of the head entry.
module if_id_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic            clk,
    input logic            reset,
    if_id_queue_if.slave   q
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_instn [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_r;

    logic          ready;
    logic          valid;
    logic          push;
    logic          pop;
    logic [31:0]   head_instn;
    logic [31:0]   head_pc;
    logic          is_jump;

    // in_ready looks only at registered occupancy, so a full queue never bypasses
    always_comb begin
        ready      = count_r < CW'(DEPTH);
        valid      = count_r != '0;
        push       = q.in_valid && ready && !q.flush;
        pop        = valid && !q.stall_flag && !q.flush;
        head_instn = valid ? mem_instn[rd_ptr] : NOP_WORD;
        head_pc    = valid ? mem_pc[rd_ptr] : '0;
        is_jump    = valid && (head_instn[31:26] == 6'b000010 ||
                               head_instn[31:26] == 6'b000011);
    end

    assign q.in_ready     = ready;
    assign q.out_valid    = valid;
    assign q.out_instn    = head_instn;
    assign q.out_pc       = head_pc;
    assign q.out_pc_plus4 = head_pc + 32'd4;
    assign q.jump_detect  = is_jump;
    assign q.jump_address = is_jump ? head_instn[25:0] : '0;
    assign q.count        = count_r;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instn[wr_ptr] <= q.in_instn;
            mem_pc[wr_ptr]    <= q.in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || q.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count_r <= count_r + CW'(1);
            else if (pop && !push)
                count_r <= count_r - CW'(1);
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reference queue model plus scoreboard of
// accepted {instn, pc} pairs, checked every cycle with immediate assertions.
module tb_if_id_queue;
    localparam int unsigned DEPTH = 2;

    typedef struct packed {
        logic [31:0] instn;
        logic [31:0] pc;
    } ent_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    ent_t exp_q[$];

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive inputs before calling; checks settled outputs, then advances one edge.
    task automatic cycle();
        logic        accept;
        logic        do_pop;
        logic [31:0] e_instn;
        logic [31:0] e_pc;
        logic        e_jump;
        ent_t        front;
        #1;
        e_instn = (exp_q.size() != 0) ? exp_q[0].instn : 32'h0000_0000;
        e_pc    = (exp_q.size() != 0) ? exp_q[0].pc : 32'h0000_0000;
        e_jump  = (exp_q.size() != 0) && (e_instn[31:26] == 6'h02 || e_instn[31:26] == 6'h03);
        chk("count",        32'(bus.count),        32'(exp_q.size()));
        chk("in_ready",     32'(bus.in_ready),     32'(exp_q.size() < DEPTH));
        chk("out_valid",    32'(bus.out_valid),    32'(exp_q.size() != 0));
        chk("out_instn",    bus.out_instn,         e_instn);
        chk("out_pc",       bus.out_pc,            e_pc);
        chk("out_pc_plus4", bus.out_pc_plus4,      e_pc + 32'd4);
        chk("jump_detect",  32'(bus.jump_detect),  32'(e_jump));
        chk("jump_address", 32'(bus.jump_address), e_jump ? {6'b0, e_instn[25:0]} : 32'h0);
        accept = bus.in_valid && (exp_q.size() < DEPTH) && !bus.flush;
        do_pop = (exp_q.size() != 0) && !bus.stall_flag && !bus.flush;
        @(posedge clk);
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                front = exp_q.pop_front();
                chk("pop_pc", bus.out_pc, front.pc);
            end
            if (accept)
                exp_q.push_back('{instn: bus.in_instn, pc: bus.in_pc});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] instn, input logic [31:0] pc,
                         input logic stall, input logic fl);
        bus.in_valid   = v;
        bus.in_instn   = instn;
        bus.in_pc      = pc;
        bus.stall_flag = stall;
        bus.flush      = fl;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive(1'b1, 32'h2000_0abc, 32'h0000_0abc, 1'b0, 1'b0);
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held two cycles with in_valid asserted
        do_reset(2);
        cycle();

        // Fill with stall, then attempt a third push for 5 cycles
        drive(1'b1, 32'h2000_0000, 32'h00, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h2000_0004, 32'h04, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h2000_0008, 32'h08, 1'b1, 1'b0);
        repeat (5) cycle();
        chk("full_count", 32'(bus.count), 32'd2);
        chk("full_head",  bus.out_pc,     32'h00);
        // Release stall: pop while full, in_ready rises the next cycle
        drive(1'b1, 32'h2000_0008, 32'h08, 1'b0, 1'b0); cycle();
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) cycle();

        // Streaming 0x00..0x3C with stall low
        for (int unsigned i = 0; i < 16; i++) begin
            drive(1'b1, 32'h2400_0000 | (i * 4), i * 4, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (2) cycle();

        // Flush with a simultaneous push; pc 0x10 must never surface
        drive(1'b1, 32'h2000_0100, 32'h100, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h2000_0104, 32'h104, 1'b1, 1'b0); cycle();
        drive(1'b1, 32'h2000_0010, 32'h010, 1'b1, 1'b1); cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) cycle();

        // Jump predecode: J at head while stalled, then JAL, then addi
        drive(1'b1, 32'h0800_0019, 32'h200, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);                 cycle();
        chk("j_detect",   32'(bus.jump_detect),  32'd1);
        chk("j_address",  32'(bus.jump_address), 32'h19);
        drive(1'b1, 32'h0c00_0123, 32'h204, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h2008_0005, 32'h208, 1'b0, 1'b0); cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);                 cycle();
        cycle();

        // PC wrap on out_pc_plus4
        drive(1'b1, 32'h2000_0001, 32'hFFFF_FFFC, 1'b1, 1'b0); cycle();
        drive(1'b0, '0, '0, 1'b1, 1'b0);                       cycle();
        chk("pc_wrap", bus.out_pc_plus4, 32'h0000_0000);

        // Reset mid-operation with a full queue discards everything
        drive(1'b1, 32'h2000_0300, 32'h300, 1'b1, 1'b0); cycle();
        do_reset(1);
        repeat (2) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue and pipeline register between the fetch stage and decode. It holds up to DEPTH fetched instruction/PC pairs so fetch can run ahead while decode is stalled. It drops all held instructions on a taken branch or jump redirect, and predecodes J/JAL at the head so decode sees the jump target one stage early. It consumes the instruction word and fetch PC produced by instruction memory and feeds the decode/register-file stage.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, minimum 2
- NOP_WORD, 32'h0000_0000, value driven on out_instn when the queue is empty

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  fetch presents a valid instruction
- in_instn  input  32  fetched instruction word
- in_pc  input  32  PC of in_instn
- in_ready  output  1  queue accepts a push this cycle
- stall_flag  input  1  decode cannot accept; suppresses pop
- flush  input  1  taken branch/jump redirect; discard all contents
- out_valid  output  1  head entry is valid
- out_instn  output  32  head instruction, or NOP_WORD when empty
- out_pc  output  32  head PC, or 0 when empty
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32
- jump_detect  output  1  head is J (opcode 6'b000010) or JAL (6'b000011) and out_valid=1
- jump_address  output  26  out_instn[25:0] when jump_detect=1, else 0
- count  output  $clog2(DEPTH+1)  number of valid entries

## Operation
- Storage: circular buffer of DEPTH {instn, pc} entries with read pointer, write pointer and occupancy count. Both pointers wrap modulo DEPTH.
- in_ready = (count < DEPTH). It is combinational from registered count only and never depends on the pop in the same cycle, so there is no full-bypass.
- Push: when in_valid && in_ready && !flush, write {in_instn, in_pc} at the write pointer and advance it.
- Pop: when out_valid && !stall_flag && !flush, advance the read pointer.
- Count: +1 on push only, −1 on pop only, unchanged when push and pop occur together.
- Flush has priority over push and pop. On flush, pointers and count go to 0 and the same-cycle push is dropped. Entry contents need not be cleared.
- The reset value of every output is: in_ready=1, out_valid=0, out_instn=NOP_WORD, out_pc=0, out_pc_plus4=4, jump_detect=0, jump_address=0, count=0. Reset takes priority over flush and pops. Reset asserted mid-operation discards all entries.
- Head outputs are driven combinationally from the registered entry at the read pointer, gated by out_valid = (count != 0).
- Predecode examines only the head entry. Non-head entries are never decoded.
- in_instn and in_pc are ignored when in_valid=0.

## Timing
- Latency: an entry pushed at edge N appears on the head outputs in the cycle after edge N, if the queue was empty.
- An entry popped at edge N is replaced at the head by the next entry in the cycle after edge N. If no next entry exists, out_valid=0 in that cycle.
- Throughput: one push and one pop per cycle are sustained when 0 < count < DEPTH.
- Full with stall_flag=1: in_ready=0, and the head and count hold indefinitely.
- Full with stall_flag=0: a pop occurs, but in_ready stays 0 that cycle. in_ready rises the cycle after the pop.
- Empty with in_valid=1: push occurs, no pop is possible (out_valid=0).
- Flush at edge N: out_valid=0, count=0 and in_ready=1 in the cycle after edge N. A push is accepted again from that cycle onward.
- stall_flag has no effect on push acceptance.

## Test plan
- Reset: hold reset for 2 cycles with in_valid=1 -> count=0, out_valid=0, out_instn=0, out_pc_plus4=4, in_ready=1 after release.
- Fill and stall (DEPTH=2, stall_flag=1):
  - Push pc 0x00 then 0x04 -> count=2, in_ready=0.
  - A third push of 0x08 is not accepted.
  - Head stays pc=0x00 for 5 cycles.
  - Releasing stall drains 0x00 and 0x04 in order; 0x08 is accepted once in_ready rises.
- Streaming: continuous pushes of pc 0x00..0x3C with stall_flag=0 -> out_pc follows in_pc delayed one cycle, count holds at 1, and pointers wrap at least 8 times with no loss or reordering.
- Flush with push: with count=2, assert flush together with in_valid=1 (pc 0x10) -> next cycle count=0 and out_valid=0; pc 0x10 never appears at the output.
- Jump predecode: push in_instn=32'h0800_0019 -> jump_detect=1 and jump_address=26'h19 while at the head. Pushing 32'h2008_0005 (addi) -> jump_detect=0 and jump_address=0.
- PC wrap: push in_pc=32'hFFFF_FFFC -> out_pc_plus4=32'h0000_0000.
